// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code datapath: width limits and the
// binary<->Gray conversion functions used by the encoder and decoder.
package gray_pkg;

  // Narrowest counter that still gives a meaningful Gray sequence.
  localparam int GRAY_W_MIN = 2;
  // Widest value the conversion helpers operate on; callers zero-extend.
  localparam int GRAY_W_MAX = 32;

  // Binary to Gray; upper bits must be zero for narrower callers.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB; zero upper bits are harmless.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Combinational binary-to-Gray encoder of parameterised width.
module bin2gray_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Encode via the shared package helper, truncated back to WIDTH.
  always_comb begin
    gray = WIDTH'(bin2gray(GRAY_W_MAX'(bin)));
  end

endmodule

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // One prefix-XOR reduction per output bit keeps the logic loop-free.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_code_counter.sv
// Binary up/down counter with registered Gray-code output, end flags and
// a one-cycle wrap pulse. Optional integrity checker enabled by the
// GRAY_CHECK_EN macro, which adds a sticky err output.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
`ifdef GRAY_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             at_max_reg, at_min_reg, wrap_reg, wrap_next;

  // Next count: load beats enable; ends either wrap (with a pulse) or hold.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_reg == MAX_VAL) begin
          if (!SATURATE) begin
            bin_next  = '0;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_reg + ONE;
        end
      end else begin
        if (bin_reg == '0) begin
          if (!SATURATE) begin
            bin_next  = MAX_VAL;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_reg - ONE;
        end
      end
    end
  end

  bin2gray_comb #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // All outputs register together from bin_next so they stay coherent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_reg    <= '0;
      gray_reg   <= '0;
      at_max_reg <= 1'b0;
      at_min_reg <= 1'b1;
      wrap_reg   <= 1'b0;
    end else begin
      bin_reg    <= bin_next;
      gray_reg   <= gray_next;
      at_max_reg <= (bin_next == MAX_VAL);
      at_min_reg <= (bin_next == '0);
      wrap_reg   <= wrap_next;
    end
  end

  assign bin_out  = bin_reg;
  assign gray_out = gray_reg;
  assign at_max   = at_max_reg;
  assign at_min   = at_min_reg;
  assign wrap     = wrap_reg;

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;
  logic             err_reg;

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_reg),
    .bin  (dec_bin)
  );

  // More than one bit set in the step difference: x & (x-1) clears the lowest.
  always_comb begin
    gray_diff = gray_next ^ gray_reg;
    multi_bit = |(gray_diff & (gray_diff - ONE));
  end

  // Sticky error: decode disagrees with count, or a counted step is not single-bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((dec_bin != bin_reg) || (!load && multi_bit)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed table-driven bench for gray_code_counter (WIDTH=4), with a
// wrapping instance (d0) and a saturating instance (d1) on shared inputs.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_bin;
  logic [3:0] bin0, gray0, bin1, gray1;
  logic       max0, min0, wrap0, max1, min1, wrap1;
`ifdef GRAY_CHECK_EN
  logic       err0, err1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(4), .SATURATE(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(bin0), .gray_out(gray0), .at_max(max0), .at_min(min0), .wrap(wrap0)
`ifdef GRAY_CHECK_EN
    , .err(err0)
`endif
  );

  gray_code_counter #(.WIDTH(4), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(bin1), .gray_out(gray1), .at_max(max1), .at_min(min1), .wrap(wrap1)
`ifdef GRAY_CHECK_EN
    , .err(err1)
`endif
  );

  typedef struct {
    logic       rst_n, en, up, load;
    logic [3:0] load_bin;
    logic [3:0] exp_bin, exp_gray;
    logic       exp_max, exp_min, exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lb, input logic [3:0] eb, input logic [3:0] eg,
                     input logic emax, input logic emin, input logic ewrap);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.load = l; v.load_bin = lb;
    v.exp_bin = eb; v.exp_gray = eg; v.exp_max = emax; v.exp_min = emin; v.exp_wrap = ewrap;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lb);
    rst_n = r; en = e; up = u; load = l; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                      input logic emax, input logic emin, input logic ewrap);
    chk({tag, ".bin"},  32'(bin1),  32'(eb));
    chk({tag, ".gray"}, 32'(gray1), 32'(eg));
    chk({tag, ".max"},  32'(max1),  32'(emax));
    chk({tag, ".min"},  32'(min1),  32'(emin));
    chk({tag, ".wrap"}, 32'(wrap1), 32'(ewrap));
    $display("sat  %s: bin=%b gray=%b max=%b min=%b wrap=%b", tag, bin1, gray1, max1, min1, wrap1);
  endtask

  initial begin
    logic [3:0] prev_gray;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'd0;

    //   rst en up ld  lbin  bin    gray    max min wrap
    add(0, 0, 1, 0, 4'd0, 4'd0,  4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 4'd0, 4'd1,  4'b0001, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd2,  4'b0011, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd3,  4'b0010, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd4,  4'b0110, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd5,  4'b0111, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd6,  4'b0101, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd7,  4'b0100, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd8,  4'b1100, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd9,  4'b1101, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd10, 4'b1111, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd11, 4'b1110, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd12, 4'b1010, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd13, 4'b1011, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd14, 4'b1001, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd15, 4'b1000, 1, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd0,  4'b0000, 0, 1, 1);
    add(1, 0, 1, 0, 4'd0, 4'd0,  4'b0000, 0, 1, 0);
    add(1, 0, 0, 1, 4'd9, 4'd9,  4'b1101, 0, 0, 0);
    add(1, 1, 0, 0, 4'd0, 4'd8,  4'b1100, 0, 0, 0);
    add(1, 1, 0, 1, 4'd0, 4'd0,  4'b0000, 0, 1, 0);
    add(1, 1, 0, 0, 4'd0, 4'd15, 4'b1000, 1, 0, 1);
    add(1, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd0,  4'b0000, 0, 1, 1);
    add(1, 0, 1, 1, 4'd6, 4'd6,  4'b0101, 0, 0, 0);
    add(0, 1, 1, 1, 4'd12, 4'd0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 4'd0, 4'd1,  4'b0001, 0, 0, 0);
    add(1, 1, 1, 1, 4'd3, 4'd3,  4'b0010, 0, 0, 0);
    add(1, 1, 1, 0, 4'd0, 4'd4,  4'b0110, 0, 0, 0);
    add(1, 1, 0, 0, 4'd0, 4'd3,  4'b0010, 0, 0, 0);

    prev_gray = 4'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_bin);
      chk($sformatf("v%0d.bin", i),  32'(bin0),  32'(vecs[i].exp_bin));
      chk($sformatf("v%0d.gray", i), 32'(gray0), 32'(vecs[i].exp_gray));
      chk($sformatf("v%0d.max", i),  32'(max0),  32'(vecs[i].exp_max));
      chk($sformatf("v%0d.min", i),  32'(min0),  32'(vecs[i].exp_min));
      chk($sformatf("v%0d.wrap", i), 32'(wrap0), 32'(vecs[i].exp_wrap));
      if (i > 0 && vecs[i].rst_n && !vecs[i].load)
        chk($sformatf("v%0d.onebit", i), 32'($countones(gray0 ^ prev_gray) <= 1), 32'd1);
      prev_gray = gray0;
      $display("vec %0d: rst_n=%b en=%b up=%b load=%b lb=%0d -> bin=%0d gray=%b max=%b min=%b wrap=%b",
               i, vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_bin,
               bin0, gray0, max0, min0, wrap0);
    end

    // Saturating instance: hold at both ends without wrap.
    drive(0, 0, 1, 0, 4'd0);  chk1("s_rst",  4'd0,  4'b0000, 0, 1, 0);
    drive(1, 1, 0, 0, 4'd0);  chk1("s_dn0",  4'd0,  4'b0000, 0, 1, 0);
    drive(1, 0, 1, 1, 4'd13); chk1("s_ld13", 4'd13, 4'b1011, 0, 0, 0);
    drive(1, 1, 1, 0, 4'd0);  chk1("s_14",   4'd14, 4'b1001, 0, 0, 0);
    drive(1, 1, 1, 0, 4'd0);  chk1("s_15",   4'd15, 4'b1000, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, 4'd0);
      chk1($sformatf("s_hold%0d", k), 4'd15, 4'b1000, 1, 0, 0);
    end
    drive(1, 1, 0, 0, 4'd0);  chk1("s_back", 4'd14, 4'b1001, 0, 0, 0);

`ifdef GRAY_CHECK_EN
    // Full sweeps keep err low; a corrupted gray register sets it stickily.
    drive(0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 16; k++) drive(1, 1, 1, 0, 4'd0);
    for (int k = 0; k < 16; k++) drive(1, 1, 0, 0, 4'd0);
    chk("err_sweep", 32'(err0), 32'd0);
    chk("err_sweep_bin", 32'(bin0), 32'd0);
    $display("chk  sweep: err=%b bin=%0d", err0, bin0);
    rst_n = 1'b1; en = 1'b0; load = 1'b0;
    force d0.gray_reg = 4'b0001;
    @(posedge clk); #1;
    release d0.gray_reg;
    chk("err_set", 32'(err0), 32'd1);
    drive(1, 0, 1, 0, 4'd0);
    drive(1, 0, 1, 0, 4'd0);
    chk("err_sticky", 32'(err0), 32'd1);
    drive(0, 0, 1, 0, 4'd0);
    chk("err_clr", 32'(err0), 32'd0);
    $display("chk  force: err cleared by reset=%b", ~err0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
